byte_unstrip: RTL and testbench



---
 rtl/byte_unstrip.sv | 207 ++++++++++++++++++++
 tb/tb_byte_unstrip.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstrip.sv
// byte_unstrip: receive-side lane de-striper. Accepts one LANES-wide word per
// handshake, replays the lanes one byte per clock (lane 0 first), checks
// packet framing, drops fill symbols and reports packet boundaries, length
// and framing errors.
module byte_unstrip #(
  parameter int LANES = 4,
  parameter int BITS  = 7,
  parameter int LEN_W = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_L,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [(BITS+1)*LANES-1:0] LANE_D,
  input  logic [LANES-1:0]          LANE_DK,
  output logic [BITS:0]             O_D,
  output logic                      O_DK,
  output logic                      O_VALID,
  output logic                      PKT_START,
  output logic                      PKT_DONE,
  output logic                      PKT_ABORT,
  output logic [LEN_W-1:0]          PKT_LEN,
  output logic                      ERR,
  output logic [2:0]                ERR_CODE
);

  localparam int BW    = BITS + 1;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  localparam logic [BITS:0] SYM_STP = BW'(8'hFB);
  localparam logic [BITS:0] SYM_SDP = BW'(8'h5C);
  localparam logic [BITS:0] SYM_END = BW'(8'hFD);
  localparam logic [BITS:0] SYM_EDB = BW'(8'hFE);
  localparam logic [BITS:0] SYM_COM = BW'(8'hBC);
  localparam logic [BITS:0] SYM_SKP = BW'(8'h1C);
  localparam logic [BITS:0] SYM_IDL = BW'(8'h7C);

  typedef enum logic {S_IDLE, S_PKT} state_t;

  // Length counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  // Serialiser state: buffered word, lane pointer, occupancy
  logic [BW*LANES-1:0] word_q;
  logic [LANES-1:0]    dk_q;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;

  // Framing state
  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;

  // Registered outputs
  logic [BITS:0]       od_q, od_d;
  logic                odk_q, odk_d;
  logic                ov_q, ov_d;
  logic                st_q, st_d;
  logic                dn_q, dn_d;
  logic                ab_q, ab_d;
  logic [LEN_W-1:0]    plen_q, plen_d;
  logic                err_q, err_d;
  logic [2:0]          code_q, code_d;

  // Current slot decode
  logic [BITS:0]       cur_b;
  logic                cur_dk;
  logic                is_start, is_end, is_fill;
  logic                is_first, is_last;
  logic                in_acc;

  // Pick the byte of the lane being replayed and classify it.
  always_comb begin
    cur_b    = word_q[BW*int'(idx_q) +: BW];
    cur_dk   = dk_q[idx_q];
    is_first = (idx_q == '0);
    is_last  = (idx_q == LAST_LANE);
    is_start = cur_dk && ((cur_b == SYM_STP) || (cur_b == SYM_SDP));
    is_end   = cur_dk && ((cur_b == SYM_END) || (cur_b == SYM_EDB));
    is_fill  = cur_dk && ((cur_b == SYM_SKP) || (cur_b == SYM_IDL) || (cur_b == SYM_COM));
    // Ready while the last lane is going out keeps back-to-back words bubble-free.
    IN_READY = !busy_q || is_last;
    in_acc   = IN_VALID && IN_READY;
  end

  // Framing decision for the byte in the current slot.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ov_d    = 1'b0;
    st_d    = 1'b0;
    dn_d    = 1'b0;
    ab_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    plen_d  = plen_q;
    if (busy_q) begin
      if (state_q == S_IDLE) begin
        if (is_start) begin
          if (is_first) begin
            state_d = S_PKT;
            st_d    = 1'b1;
            ov_d    = 1'b1;
            len_d   = '0;
          end else begin
            err_d  = 1'b1;
            code_d = 3'd1;
          end
        end else if (is_end) begin
          err_d  = 1'b1;
          code_d = 3'd5;
        end else if (!is_fill) begin
          err_d  = 1'b1;
          code_d = 3'd3;
        end
      end else begin
        if (is_start) begin
          // A new start inside a packet abandons the open one.
          err_d   = 1'b1;
          code_d  = 3'd4;
          state_d = S_IDLE;
          ab_d    = 1'b1;
          plen_d  = len_q;
        end else if (is_end) begin
          if (is_last) begin
            state_d = S_IDLE;
            ov_d    = 1'b1;
            plen_d  = len_q;
            if (cur_b == SYM_END) dn_d = 1'b1;
            else                  ab_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 3'd2;
          end
        end else if (is_fill) begin
          err_d  = 1'b1;
          code_d = 3'd6;
        end else begin
          ov_d  = 1'b1;
          len_d = sat_inc(len_q);
        end
      end
    end
    // Dropped slots leave the previous byte on the output.
    od_d  = ov_d ? cur_b  : od_q;
    odk_d = ov_d ? cur_dk : odk_q;
  end

  // Word buffer payload; only meaningful while busy_q is set.
  always_ff @(posedge CLK) begin
    if (in_acc) begin
      word_q <= LANE_D;
      dk_q   <= LANE_DK;
    end
  end

  // Control, framing and output registers.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      idx_q   <= '0;
      busy_q  <= 1'b0;
      state_q <= S_IDLE;
      len_q   <= '0;
      od_q    <= '0;
      odk_q   <= 1'b0;
      ov_q    <= 1'b0;
      st_q    <= 1'b0;
      dn_q    <= 1'b0;
      ab_q    <= 1'b0;
      plen_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      if (in_acc) begin
        idx_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (is_last) busy_q <= 1'b0;
        else         idx_q  <= idx_q + IDX_W'(1);
      end
      state_q <= state_d;
      len_q   <= len_d;
      od_q    <= od_d;
      odk_q   <= odk_d;
      ov_q    <= ov_d;
      st_q    <= st_d;
      dn_q    <= dn_d;
      ab_q    <= ab_d;
      plen_q  <= plen_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign O_D       = od_q;
  assign O_DK      = odk_q;
  assign O_VALID   = ov_q;
  assign PKT_START = st_q;
  assign PKT_DONE  = dn_q;
  assign PKT_ABORT = ab_q;
  assign PKT_LEN   = plen_q;
  assign ERR       = err_q;
  assign ERR_CODE  = code_q;

endmodule

// File: tb/tb_byte_unstrip.sv
// tb_byte_unstrip: directed bench for byte_unstrip (LANES=4, 8-bit bytes).
// A negedge monitor logs every cycle; each test inspects the log relative to
// the cycle in which its words were accepted.
module tb_byte_unstrip;

  logic        CLK;
  logic        RESET_L;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] LANE_D;
  logic [3:0]  LANE_DK;
  logic [7:0]  O_D;
  logic        O_DK;
  logic        O_VALID;
  logic        PKT_START;
  logic        PKT_DONE;
  logic        PKT_ABORT;
  logic [15:0] PKT_LEN;
  logic        ERR;
  logic [2:0]  ERR_CODE;

  byte_unstrip #(.LANES(4), .BITS(7), .LEN_W(16)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .LANE_D(LANE_D), .LANE_DK(LANE_DK), .O_D(O_D), .O_DK(O_DK), .O_VALID(O_VALID),
    .PKT_START(PKT_START), .PKT_DONE(PKT_DONE), .PKT_ABORT(PKT_ABORT),
    .PKT_LEN(PKT_LEN), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        dk;
    logic        st;
    logic        dn;
    logic        ab;
    logic [15:0] len;
    logic        err;
    logic [2:0]  code;
    logic        rdy;
    logic        acc;
  } ent_t;

  ent_t        lg[$];
  ent_t        mon_e;
  logic [7:0]  expq[$];
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Per-cycle log; acc marks a word accepted on the following rising edge.
  always @(negedge CLK) begin
    mon_e.v    = O_VALID;
    mon_e.d    = O_D;
    mon_e.dk   = O_DK;
    mon_e.st   = PKT_START;
    mon_e.dn   = PKT_DONE;
    mon_e.ab   = PKT_ABORT;
    mon_e.len  = PKT_LEN;
    mon_e.err  = ERR;
    mon_e.code = ERR_CODE;
    mon_e.rdy  = IN_READY;
    mon_e.acc  = IN_VALID & IN_READY;
    lg.push_back(mon_e);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present a word until it is taken (bounded), then drop IN_VALID.
  task automatic send_word(input logic [31:0] d, input logic [3:0] dk);
    logic rdy;
    int   n;
    n = 0;
    LANE_D   = d;
    LANE_DK  = dk;
    IN_VALID = 1'b1;
    do begin
      rdy = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 50);
    chk("send_ready", rdy, 1'b1);
    IN_VALID = 1'b0;
  endtask

  function automatic int nth_acc(input int n);
    int c;
    c = 0;
    foreach (lg[k]) begin
      if (lg[k].acc) begin
        if (c == n) return k;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic logic idx_ok(input int b, input int span);
    return (b >= 0) && (b + span < lg.size());
  endfunction

  initial begin : main
    int a0, a1, ne, nacc, nlow, ndn, nv;
    logic [7:0] t1_exp [8];
    logic [2:0] t3_code [4];

    RESET_L  = 1'b0;
    IN_VALID = 1'b0;
    LANE_D   = '0;
    LANE_DK  = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ovalid", O_VALID, 1'b0);
    chk("rst_od", O_D, 8'h00);
    chk("rst_pkt_len", PKT_LEN, 16'h0);
    chk("rst_err", ERR, 1'b0);
    RESET_L = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_ready", IN_READY, 1'b1);

    // Test 1: back-to-back packet FB 11 22 33 | 44 55 66 FD
    t1_exp = '{8'hFB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFD};
    lg.delete();
    send_word(32'h3322_11FB, 4'b0001);
    send_word(32'hFD66_5544, 4'b1000);
    idle(8);
    a0 = nth_acc(0);
    a1 = nth_acc(1);
    chk("t1_no_bubble", a1 - a0, 4);
    chk("t1_idx", idx_ok(a0, 9), 1'b1);
    if (idx_ok(a0, 9)) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t1_valid%0d", i), lg[a0+2+i].v, 1'b1);
        chk($sformatf("t1_byte%0d", i), lg[a0+2+i].d, t1_exp[i]);
      end
      chk("t1_dk0", lg[a0+2].dk, 1'b1);
      chk("t1_start", lg[a0+2].st, 1'b1);
      chk("t1_done", lg[a0+9].dn, 1'b1);
      chk("t1_len", lg[a0+9].len, 16'd6);
      chk("t1_no_err", lg[a0+5].err, 1'b0);
    end

    // Test 2: fill word in IDLE is silently dropped
    lg.delete();
    send_word(32'h7C1C_7C7C, 4'b1111);
    idle(6);
    a0 = nth_acc(0);
    chk("t2_idx", idx_ok(a0, 5), 1'b1);
    if (idx_ok(a0, 5)) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_valid%0d", i), lg[a0+2+i].v, 1'b0);
        chk($sformatf("t2_err%0d", i), lg[a0+2+i].err, 1'b0);
        chk($sformatf("t2_pkt%0d", i), {lg[a0+2+i].st, lg[a0+2+i].dn, lg[a0+2+i].ab}, 3'b000);
      end
    end

    // Test 3: data and misplaced start in IDLE
    t3_code = '{3'd3, 3'd1, 3'd3, 3'd3};
    lg.delete();
    send_word(32'h3322_FB11, 4'b0010);
    idle(6);
    a0 = nth_acc(0);
    chk("t3_idx", idx_ok(a0, 5), 1'b1);
    if (idx_ok(a0, 5)) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_err%0d", i), lg[a0+2+i].err, 1'b1);
        chk($sformatf("t3_code%0d", i), lg[a0+2+i].code, t3_code[i]);
        chk($sformatf("t3_valid%0d", i), lg[a0+2+i].v, 1'b0);
      end
    end

    // Test 4: open packet (3 data), then AA FD BB FE
    lg.delete();
    send_word(32'h0302_01FB, 4'b0001);
    send_word(32'hFEBB_FDAA, 4'b1010);
    idle(8);
    a1 = nth_acc(1);
    chk("t4_idx", idx_ok(a1, 5), 1'b1);
    if (idx_ok(a1, 5)) begin
      chk("t4_aa_valid", lg[a1+2].v, 1'b1);
      chk("t4_aa_byte", lg[a1+2].d, 8'hAA);
      chk("t4_fd_valid", lg[a1+3].v, 1'b0);
      chk("t4_fd_err", lg[a1+3].err, 1'b1);
      chk("t4_fd_code", lg[a1+3].code, 3'd2);
      chk("t4_bb_byte", {lg[a1+4].v, lg[a1+4].d}, {1'b1, 8'hBB});
      chk("t4_fe_byte", {lg[a1+5].v, lg[a1+5].dk, lg[a1+5].d}, {1'b1, 1'b1, 8'hFE});
      chk("t4_abort", {lg[a1+5].ab, lg[a1+5].dn}, 2'b10);
      chk("t4_len", lg[a1+5].len, 16'd5);
    end

    // Test 5: random IN_VALID gaps inside one long packet
    lg.delete();
    expq.delete();
    send_word(32'h0302_01FB, 4'b0001);
    expq.push_back(8'hFB); expq.push_back(8'h01); expq.push_back(8'h02); expq.push_back(8'h03);
    for (int w = 0; w < 20; w++) begin
      idle($urandom_range(0, 2));
      rd = $urandom();
      send_word(rd, 4'b0000);
      for (int l = 0; l < 4; l++) expq.push_back(rd[8*l +: 8]);
    end
    idle($urandom_range(0, 2));
    send_word(32'hFD33_2211, 4'b1000);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33); expq.push_back(8'hFD);
    idle(8);
    ne = 0; nacc = 0; nlow = 0; ndn = 0;
    foreach (lg[k]) begin
      if (lg[k].v) begin
        if (ne < expq.size()) chk($sformatf("t5_byte%0d", ne), lg[k].d, expq[ne]);
        ne++;
      end
      if (lg[k].acc) nacc++;
      if (!lg[k].rdy) nlow++;
      if (lg[k].dn) begin
        ndn++;
        chk("t5_len", lg[k].len, 16'd86);
      end
    end
    chk("t5_count", ne, expq.size());
    chk("t5_accepts", nacc, 22);
    chk("t5_ready_low", nlow, 3 * nacc);
    chk("t5_done_cnt", ndn, 1);

    // Test 6: reset in slot 2 of an in-packet word
    lg.delete();
    send_word(32'h0302_01FB, 4'b0001);
    send_word(32'h0706_0504, 4'b0000);
    repeat (3) @(posedge CLK);
    #3;
    RESET_L = 1'b0;
    #1;
    chk("t6_ovalid", O_VALID, 1'b0);
    chk("t6_od", O_D, 8'h00);
    chk("t6_pkt_len", PKT_LEN, 16'h0);
    chk("t6_err_code", ERR_CODE, 3'd0);
    chk("t6_pulses", {PKT_START, PKT_DONE, PKT_ABORT, ERR, O_DK}, 5'b0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    chk("t6_ready", IN_READY, 1'b1);
    lg.delete();
    send_word(32'h4433_2211, 4'b0000);
    idle(6);
    a0 = nth_acc(0);
    chk("t6_idx", idx_ok(a0, 5), 1'b1);
    if (idx_ok(a0, 5)) begin
      chk("t6_err", lg[a0+2].err, 1'b1);
      chk("t6_code", lg[a0+2].code, 3'd3);
    end
    nv = 0;
    foreach (lg[k]) if (lg[k].v) nv++;
    chk("t6_no_emit", nv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
